lightgun_arbiter: RTL and testbench

Shares the single console HL (external latch) input between two lightgun instances: gun A is the Menacer/Justifier blue gun, gun B is the Justifier pink gun. It schedules which gun owns the HL line per frame (single-gun or alternating), stretches and rate-limits HL pulses, latches beam H/V position at each accepted hit, and merges the two crosshair overlays. It sits between the two lightgun instances and the I/O port / VDP HL logic.

---
 rtl/lightgun_arbiter.sv | 167 ++++++++++++++++
 tb/tb_lightgun_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lightgun_arbiter.sv
// lightgun_arbiter: shares the console HL latch between two lightguns,
// schedules per-frame HL ownership and merges the crosshair overlays.
module lightgun_arbiter #(
    parameter logic [7:0] SLOT_FRAMES = 8'd1,
    parameter logic [7:0] HL_WIDTH    = 8'd32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE_PIX,
    input  logic       HDE,
    input  logic       VDE,
    input  logic [1:0] MODE,
    input  logic       SENSOR_A,
    input  logic       SENSOR_B,
    input  logic [2:0] TARGET_A,
    input  logic [2:0] TARGET_B,
    output logic       HL,
    output logic       GUN_SEL,
    output logic       HIT_VALID,
    output logic [9:0] HPOS,
    output logic [8:0] VPOS,
    output logic [2:0] TARGET
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [7:0] SLOT_LIM = (SLOT_FRAMES == 8'd0) ? 8'd1 : SLOT_FRAMES;

    state_t     r_state;
    state_t     w_state_n;
    logic [7:0] r_slot;
    logic [7:0] w_slot_n;
    logic [7:0] w_slot_inc;
    logic [1:0] r_mode;
    logic       r_vde_prev;
    logic       r_hde_prev;
    logic [9:0] r_hcnt;
    logic [8:0] r_vcnt;
    logic [2:0] r_sync_a;
    logic [2:0] r_sync_b;
    logic       r_hit_done;
    logic [7:0] r_str;
    logic       r_hl;
    logic       r_gun_sel;
    logic       r_hit_valid;
    logic [9:0] r_hpos;
    logic [8:0] r_vpos;
    logic [2:0] r_target;

    logic       w_fb;
    logic       w_hde_fall;
    logic       w_edge_a;
    logic       w_edge_b;
    logic       w_edge;
    logic       w_hit_done_n;
    logic       w_accept;
    logic [2:0] w_target_n;

    always_comb begin
        w_fb       = CE_PIX & VDE & ~r_vde_prev;
        w_hde_fall = CE_PIX & ~HDE & r_hde_prev;
        w_edge_a   = r_sync_a[1] & ~r_sync_a[2];
        w_edge_b   = r_sync_b[1] & ~r_sync_b[2];
        w_slot_inc = r_slot + 8'd1;
        w_state_n  = r_state;
        w_slot_n   = r_slot;
        if (w_fb) begin
            unique case (MODE)
                2'b00: w_state_n = IDLE;
                2'b01: w_state_n = OWN_A;
                2'b10: w_state_n = OWN_B;
                default: begin
                    if (r_state == IDLE)
                        w_state_n = OWN_A;
                    else if (w_slot_inc == SLOT_LIM)
                        w_state_n = (r_state == OWN_A) ? OWN_B : OWN_A;
                    else
                        w_slot_n = w_slot_inc;
                end
            endcase
            if (w_state_n != r_state)
                w_slot_n = 8'd0;
        end
        // the frame-boundary update lands first; the edge is judged against the new owner
        w_hit_done_n = r_hit_done & ~w_fb;
        w_edge       = (w_state_n == OWN_B) ? w_edge_b : w_edge_a;
        w_accept     = (w_state_n != IDLE) & ~w_hit_done_n
                     & (r_str == 8'd0) & ~r_hl & w_edge;
        unique case (r_mode)
            2'b01:   w_target_n = TARGET_A;
            2'b10:   w_target_n = TARGET_B;
            2'b11:   w_target_n = (TARGET_A != 3'd0) ? TARGET_A : TARGET_B;
            default: w_target_n = 3'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_slot      <= 8'd0;
            r_mode      <= 2'b00;
            r_vde_prev  <= 1'b0;
            r_hde_prev  <= 1'b0;
            r_hcnt      <= 10'd0;
            r_vcnt      <= 9'd0;
            r_sync_a    <= 3'd0;
            r_sync_b    <= 3'd0;
            r_hit_done  <= 1'b0;
            r_str       <= 8'd0;
            r_hl        <= 1'b0;
            r_gun_sel   <= 1'b0;
            r_hit_valid <= 1'b0;
            r_hpos      <= 10'd0;
            r_vpos      <= 9'd0;
            r_target    <= 3'd0;
        end else begin
            r_sync_a <= {r_sync_a[1:0], SENSOR_A};
            r_sync_b <= {r_sync_b[1:0], SENSOR_B};
            if (CE_PIX) begin
                r_vde_prev <= VDE;
                r_hde_prev <= HDE;
                if (HDE) begin
                    if (r_hcnt != 10'h3FF)
                        r_hcnt <= r_hcnt + 10'd1;
                end else if (r_hde_prev) begin
                    r_hcnt <= 10'd0;
                end
                if (w_fb)
                    r_vcnt <= 9'd0;
                else if (w_hde_fall && VDE && r_vcnt != 9'h1FF)
                    r_vcnt <= r_vcnt + 9'd1;
            end
            r_state     <= w_state_n;
            r_slot      <= w_slot_n;
            r_hit_done  <= w_hit_done_n | w_accept;
            r_hit_valid <= w_accept;
            r_target    <= w_target_n;
            if (w_fb)
                r_mode <= MODE;
            if (w_state_n == OWN_A)
                r_gun_sel <= 1'b0;
            else if (w_state_n == OWN_B)
                r_gun_sel <= 1'b1;
            if (w_accept) begin
                r_hpos <= r_hcnt;
                r_vpos <= r_vcnt;
                r_hl   <= 1'b1;
                r_str  <= HL_WIDTH;
            end else if (w_fb && w_state_n == IDLE) begin
                r_hl  <= 1'b0;
                r_str <= 8'd0;
            end else if (r_hl) begin
                if (r_str == 8'd0)
                    r_hl <= 1'b0;
                else if (CE_PIX)
                    r_str <= r_str - 8'd1;
            end
        end
    end

    assign HL        = r_hl;
    assign GUN_SEL   = r_gun_sel;
    assign HIT_VALID = r_hit_valid;
    assign HPOS      = r_hpos;
    assign VPOS      = r_vpos;
    assign TARGET    = r_target;

endmodule

// File: tb/tb_lightgun_arbiter.sv
// Bench for lightgun_arbiter: scoreboarded hits, an overlay vector table
// and hand-written frame-boundary and reset sequences.
module tb_lightgun_arbiter;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       CE_PIX;
    logic       HDE;
    logic       VDE;
    logic [1:0] MODE;
    logic       SENSOR_A;
    logic       SENSOR_B;
    logic [2:0] TARGET_A;
    logic [2:0] TARGET_B;
    logic       HL;
    logic       GUN_SEL;
    logic       HIT_VALID;
    logic [9:0] HPOS;
    logic [8:0] VPOS;
    logic [2:0] TARGET;

    always #5 CLK = ~CLK;

    lightgun_arbiter #(.SLOT_FRAMES(8'd2), .HL_WIDTH(8'd32)) dut (
        .CLK(CLK), .RESET(RESET), .CE_PIX(CE_PIX), .HDE(HDE), .VDE(VDE),
        .MODE(MODE), .SENSOR_A(SENSOR_A), .SENSOR_B(SENSOR_B),
        .TARGET_A(TARGET_A), .TARGET_B(TARGET_B), .HL(HL),
        .GUN_SEL(GUN_SEL), .HIT_VALID(HIT_VALID), .HPOS(HPOS),
        .VPOS(VPOS), .TARGET(TARGET)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int hpos;
        int vpos;
        bit chk_v;
    } hit_t;
    hit_t sb[$];
    hit_t mon_e;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] ta;
        logic [2:0] tb;
        logic [2:0] tgt;
        bit         gchk;
        bit         gsel;
    } tv_t;
    tv_t tv[8];

    // video timing; new geometry is loaded at the frame wrap
    int hact = 120, htot = 128, vact = 44, vtot = 48;
    int n_hact = 120, n_htot = 128, n_vact = 44, n_vtot = 48;
    int px = 0, ln = 0;

    initial begin
        CE_PIX = 1'b0;
        HDE = 1'b0;
        VDE = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            CE_PIX = ~CE_PIX;
            if (CE_PIX) begin
                if (px == htot - 1) begin
                    px = 0;
                    if (ln == vtot - 1) begin
                        ln = 0;
                        hact = n_hact;
                        htot = n_htot;
                        vact = n_vact;
                        vtot = n_vtot;
                    end else begin
                        ln++;
                    end
                end else begin
                    px++;
                end
                HDE = (px < hact) && (ln < vact);
                VDE = (ln < vact);
            end
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    always @(negedge CLK) begin
        if (HIT_VALID) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_hit actual=HPOS %0d VPOS %0d required=none",
                         HPOS, VPOS);
            end else begin
                mon_e = sb.pop_front();
                check("hit_hpos", int'(HPOS), mon_e.hpos);
                if (mon_e.chk_v)
                    check("hit_vpos", int'(VPOS), mon_e.vpos);
            end
        end
    end

    task automatic wait_fb();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(CE_PIX && ln == 0 && px == 0) && n < 30000);
        if (n >= 30000)
            timeout("wait_fb");
        @(negedge CLK);
    endtask

    task automatic wait_pos(int l, int p);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(CE_PIX && ln == l && px == p) && n < 30000);
        if (n >= 30000)
            timeout("wait_pos");
    endtask

    task automatic wait_hl();
        int n = 0;
        while (!HL && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200)
            timeout("wait_hl");
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("sb_drain", sb.size(), 0);
    endtask

    int ticks;
    int n;
    int hl_seen;
    bit exp_seq[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        tv[0] = '{2'b11, 3'd1, 3'd2, 3'd1, 1'b0, 1'b0};
        tv[1] = '{2'b11, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0};
        tv[2] = '{2'b11, 3'd5, 3'd0, 3'd5, 1'b0, 1'b0};
        tv[3] = '{2'b01, 3'd0, 3'd3, 3'd0, 1'b1, 1'b0};
        tv[4] = '{2'b01, 3'd4, 3'd3, 3'd4, 1'b1, 1'b0};
        tv[5] = '{2'b10, 3'd4, 3'd3, 3'd3, 1'b1, 1'b1};
        tv[6] = '{2'b10, 3'd4, 3'd0, 3'd0, 1'b1, 1'b1};
        tv[7] = '{2'b00, 3'd1, 3'd2, 3'd0, 1'b1, 1'b1};

        RESET = 1'b1;
        MODE = 2'b00;
        SENSOR_A = 1'b0;
        SENSOR_B = 1'b0;
        TARGET_A = 3'd0;
        TARGET_B = 3'd0;
        repeat (4) @(negedge CLK);
        check("rst_hl", HL, 0);
        check("rst_gun_sel", GUN_SEL, 0);
        check("rst_hit_valid", HIT_VALID, 0);
        check("rst_hpos", HPOS, 0);
        check("rst_vpos", VPOS, 0);
        check("rst_target", TARGET, 0);
        RESET = 1'b0;

        // gun A alone: hit at line 40, pixel 100
        MODE = 2'b01;
        wait_fb();
        check("gsel_mode01", GUN_SEL, 0);
        wait_pos(40, 99);
        SENSOR_A = 1'b1;
        sb.push_back(hit_t'{100, 40, 1'b1});
        wait_hl();
        ticks = 0;
        n = 0;
        while (HL && n < 500) begin
            if (CE_PIX)
                ticks++;
            @(negedge CLK);
            n++;
        end
        check("hl_width_ticks", ticks, 32);
        SENSOR_A = 1'b0;
        drain();

        wait_pos(42, 50);
        SENSOR_A = 1'b1;
        hl_seen = 0;
        repeat (80) begin
            @(negedge CLK);
            if (HL)
                hl_seen = 1;
        end
        SENSOR_A = 1'b0;
        check("hl_second_hit", hl_seen, 0);

        // mode change mid-frame waits for the next VDE rise
        MODE = 2'b10;
        repeat (4) @(negedge CLK);
        check("gsel_midframe", GUN_SEL, 0);
        n_hact = 8;
        n_htot = 12;
        n_vact = 3;
        n_vtot = 5;
        wait_fb();
        check("gsel_after_fb", GUN_SEL, 1);

        MODE = 2'b00;
        wait_fb();
        check("gsel_idle_hold", GUN_SEL, 1);

        // alternate mode with two frames per slot
        MODE = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_fb();
            check($sformatf("gsel_seq%0d", i), GUN_SEL, int'(exp_seq[i]));
            if (i == 1) begin
                wait_pos(1, 2);
                SENSOR_B = 1'b1;
                repeat (4) @(negedge CLK);
                SENSOR_B = 1'b0;
            end
        end

        // A edge landing on the A->B swap boundary is dropped
        wait_pos(4, 11);
        SENSOR_A = 1'b1;
        wait_fb();
        check("gsel_fb7", GUN_SEL, 1);
        repeat (4) @(negedge CLK);
        SENSOR_A = 1'b0;
        wait_fb();
        wait_fb();
        check("gsel_fb9", GUN_SEL, 0);
        wait_fb();

        // B edge on the next A->B boundary is taken by the new owner
        wait_pos(4, 11);
        SENSOR_B = 1'b1;
        sb.push_back(hit_t'{0, 0, 1'b0});
        wait_fb();
        check("gsel_fb11", GUN_SEL, 1);
        repeat (4) @(negedge CLK);
        SENSOR_B = 1'b0;
        drain();

        for (int i = 0; i < 8; i++) begin
            MODE = tv[i].mode;
            wait_fb();
            TARGET_A = tv[i].ta;
            TARGET_B = tv[i].tb;
            repeat (2) @(negedge CLK);
            check($sformatf("target_row%0d", i), int'(TARGET), int'(tv[i].tgt));
            check($sformatf("hl_row%0d", i), HL, 0);
            if (tv[i].gchk)
                check($sformatf("gsel_row%0d", i), GUN_SEL, int'(tv[i].gsel));
        end

        // reset in the middle of an HL pulse
        MODE = 2'b10;
        TARGET_A = 3'd0;
        TARGET_B = 3'd0;
        wait_fb();
        wait_fb();
        wait_pos(1, 3);
        SENSOR_B = 1'b1;
        sb.push_back(hit_t'{4, 1, 1'b1});
        wait_hl();
        ticks = 0;
        n = 0;
        while (ticks < 5 && n < 100) begin
            @(negedge CLK);
            n++;
            if (CE_PIX)
                ticks++;
        end
        RESET = 1'b1;
        @(negedge CLK);
        check("midrst_hl", HL, 0);
        check("midrst_gun_sel", GUN_SEL, 0);
        check("midrst_hpos", HPOS, 0);
        check("midrst_vpos", VPOS, 0);
        check("midrst_target", TARGET, 0);
        RESET = 1'b0;
        SENSOR_B = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
